// File: rtl/gray_counter_if.sv
// Control and status bundle for gray_counter: the step/load controls and the
// binary, Gray and flag outputs of the counter.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  // Handshake: no backpressure. The counter samples en/up/load/load_bin on every
  // rising edge. load beats en. en=1 requests exactly one step that cycle.
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] g;
  logic             tc;
  logic             wrap;
  logic             step_err;

  modport master (
    output en, up, load, load_bin,
    input  bin, g, tc, wrap, step_err
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, g, tc, wrap, step_err
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output derived from the
// next binary value, optional wrap or saturate, and a sticky one-bit-step monitor.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  gray_counter_if.slave cnt
);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] g_diff;
  logic             wrap_q;
  logic             err_q;
  logic             wrap_nxt;
  logic             moved;
  logic             at_max;
  logic             at_min;
  logic             one_hot;

  assign at_max = (bin_q == ALL_ONES);
  assign at_min = (bin_q == '0);

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    moved    = 1'b0;
    if (cnt.load) begin
      bin_nxt = cnt.load_bin;
    end else if (cnt.en) begin
      if (cnt.up) begin
        if (!at_max) begin
          bin_nxt = bin_q + ONE;
          moved   = 1'b1;
        end else if (WRAP) begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
          moved    = 1'b1;
        end
      end else begin
        if (!at_min) begin
          bin_nxt = bin_q - ONE;
          moved   = 1'b1;
        end else if (WRAP) begin
          bin_nxt  = ALL_ONES;
          wrap_nxt = 1'b1;
          moved    = 1'b1;
        end
      end
    end
  end

  // Gray is registered from the next binary value so it never glitches on decode.
  assign g_nxt   = bin_nxt ^ (bin_nxt >> 1);
  assign g_diff  = g_q ^ g_nxt;
  assign one_hot = (g_diff != '0) && ((g_diff & (g_diff - ONE)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      g_q    <= g_nxt;
      wrap_q <= wrap_nxt;
      if (moved && !one_hot) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cnt.bin      = bin_q;
  assign cnt.g        = g_q;
  assign cnt.wrap     = wrap_q;
  assign cnt.step_err = err_q;
  assign cnt.tc       = cnt.en & ~cnt.load &
                        ((cnt.up & at_max) | (~cnt.up & at_min));
endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a WRAP=1 and a WRAP=0 instance share stimulus and are
// checked every cycle against an arithmetic model, plus literal spot checks.
module tb_gray_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_en = 1'b0;
  logic         s_up = 1'b0;
  logic         s_load = 1'b0;
  logic [W-1:0] s_lb = '0;

  int total = 0;
  int bad = 0;

  // Model state, index 1 = wrapping instance, index 0 = saturating instance.
  int           mb[2];
  bit           mw[2];
  bit           mmv[2];
  logic [W-1:0] lg[2];

  logic [W-1:0] gseq[16];

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(W)) if1 ();
  gray_counter_if #(.WIDTH(W)) if0 ();

  assign if1.en = s_en;
  assign if1.up = s_up;
  assign if1.load = s_load;
  assign if1.load_bin = s_lb;
  assign if0.en = s_en;
  assign if0.up = s_up;
  assign if0.load = s_load;
  assign if0.load_bin = s_lb;

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .cnt(if1));
  gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .cnt(if0));

  function automatic logic [W-1:0] gray_of(int b);
    return W'(b ^ (b >> 1));
  endfunction

  // Gray to binary, as the downstream converter does it: running XOR from the MSB.
  function automatic logic [W-1:0] decode(logic [W-1:0] gg);
    logic [W-1:0] r;
    logic         acc;
    r = '0;
    acc = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      acc  = acc ^ gg[k];
      r[k] = acc;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mb[i]  = 0;
      mw[i]  = 1'b0;
      mmv[i] = 1'b0;
      lg[i]  = '0;
    end
  endtask

  task automatic model_edge();
    int nb;
    for (int i = 0; i < 2; i++) begin
      nb     = mb[i];
      mw[i]  = 1'b0;
      mmv[i] = 1'b0;
      if (s_load) begin
        nb = int'(s_lb);
      end else if (s_en) begin
        nb = s_up ? mb[i] + 1 : mb[i] - 1;
        if (nb < 0 || nb > 15) begin
          if (i == 1) begin
            nb    = (nb + 16) % 16;
            mw[i] = 1'b1;
          end else begin
            nb = mb[i];
          end
        end
        mmv[i] = (nb != mb[i]);
      end
      mb[i] = nb;
    end
  endtask

  task automatic cmp_dut(input int i, input logic [W-1:0] b, input logic [W-1:0] g,
                         input logic t, input logic w, input logic e);
    bit exp_tc;
    exp_tc = s_en && !s_load && ((s_up && mb[i] == 15) || (!s_up && mb[i] == 0));
    chk($sformatf("bin dut%0d", i), 32'(b), 32'(mb[i]));
    chk($sformatf("g dut%0d", i), 32'(g), 32'(gray_of(mb[i])));
    chk($sformatf("g_decode dut%0d", i), 32'(decode(g)), 32'(b));
    chk($sformatf("tc dut%0d", i), 32'(t), 32'(exp_tc));
    chk($sformatf("wrap dut%0d", i), 32'(w), 32'(mw[i]));
    chk($sformatf("step_err dut%0d", i), 32'(e), 32'(0));
    if (mmv[i]) begin
      chk($sformatf("one_bit_step dut%0d", i), 32'($countones(g ^ lg[i])), 32'(1));
    end
    lg[i] = g;
  endtask

  task automatic compare_all();
    cmp_dut(1, if1.bin, if1.g, if1.tc, if1.wrap, if1.step_err);
    cmp_dut(0, if0.bin, if0.g, if0.tc, if0.wrap, if0.step_err);
  endtask

  // Apply inputs just after a falling edge, update the model at the rising edge,
  // compare at the next falling edge.
  task automatic run(input logic en, input logic up, input logic ld, input logic [W-1:0] lb);
    s_en   = en;
    s_up   = up;
    s_load = ld;
    s_lb   = lb;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    s_en = 1'b0;
    s_up = 1'b0;
    s_load = 1'b0;
    s_lb = '0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    model_reset();

    // Reset state and full up sequence through the wrap.
    do_reset();
    chk("reset g", 32'(if1.g), 32'(0));
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("tc at 1111", 32'(if1.tc), 32'(1));
      run(1'b1, 1'b1, 1'b0, '0);
      chk($sformatf("seq g step %0d", k + 1), 32'(if1.g), 32'(gseq[(k + 1) % 16]));
      chk($sformatf("seq wrap step %0d", k + 1), 32'(if1.wrap), 32'(k == 15));
    end
    run(1'b0, 1'b1, 1'b0, '0);
    chk("wrap one cycle", 32'(if1.wrap), 32'(0));

    // Down from reset wraps to all-ones.
    do_reset();
    run(1'b1, 1'b0, 1'b0, '0);
    chk("down bin", 32'(if1.bin), 32'(4'b1111));
    chk("down g", 32'(if1.g), 32'(4'b1000));
    chk("down wrap", 32'(if1.wrap), 32'(1));
    chk("sat down hold", 32'(if0.bin), 32'(0));
    run(1'b1, 1'b0, 1'b0, '0);
    chk("down2 bin", 32'(if1.bin), 32'(4'b1110));
    chk("down2 g", 32'(if1.g), 32'(4'b1001));

    // Load beats en.
    run(1'b1, 1'b1, 1'b1, 4'b0101);
    chk("load bin", 32'(if1.bin), 32'(4'b0101));
    chk("load g", 32'(if1.g), 32'(4'b0111));
    chk("load wrap", 32'(if1.wrap), 32'(0));
    run(1'b0, 1'b0, 1'b1, 4'b0101);
    chk("reload same bin", 32'(if1.bin), 32'(4'b0101));

    // Saturation on the WRAP=0 instance.
    run(1'b0, 1'b0, 1'b1, 4'b1110);
    for (int k = 0; k < 3; k++) begin
      run(1'b1, 1'b1, 1'b0, '0);
      chk("sat wrap", 32'(if0.wrap), 32'(0));
    end
    chk("sat bin", 32'(if0.bin), 32'(4'b1111));
    chk("sat g", 32'(if0.g), 32'(4'b1000));
    chk("sat err", 32'(if0.step_err), 32'(0));

    // Asynchronous reset between edges.
    run(1'b0, 1'b0, 1'b1, 4'b1010);
    chk("pre-reset bin", 32'(if1.bin), 32'(4'b1010));
    s_load = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async bin", 32'(if1.bin), 32'(0));
    chk("async g", 32'(if1.g), 32'(0));
    chk("async g sat", 32'(if0.g), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 1'b1, 1'b0, '0);
    chk("post-reset g", 32'(if1.g), 32'(4'b0001));

    // Randomized traffic.
    for (int k = 0; k < 10000; k++) begin
      run($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, W'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
